// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory watchdog,
// sticky trap state and retired-instruction counter. All strobes are decoded combinationally.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic [2:0]       imm_sel,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_ALU_IMM,
    CL_UPPER,
    CL_JAL,
    CL_JALR,
    CL_OP,
    CL_ILLEGAL
  } cls_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  state_t           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  cls_t             cls;

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0000011:                         classify = CL_LOAD;
      7'b0100011:                         classify = CL_STORE;
      7'b1100011:                         classify = CL_BRANCH;
      7'b0010011, 7'b0011011:             classify = CL_ALU_IMM;
      7'b0110111, 7'b0010111:             classify = CL_UPPER;
      7'b1101111:                         classify = CL_JAL;
      7'b1100111:                         classify = CL_JALR;
      7'b0110011, 7'b0111011:             classify = CL_OP;
      default:                            classify = CL_ILLEGAL;
    endcase
  endfunction

  function automatic logic [2:0] imm_fmt(input cls_t c);
    case (c)
      CL_LOAD, CL_ALU_IMM, CL_JALR: imm_fmt = IMM_I;
      CL_STORE:                     imm_fmt = IMM_S;
      CL_BRANCH:                    imm_fmt = IMM_B;
      CL_UPPER:                     imm_fmt = IMM_U;
      CL_JAL:                       imm_fmt = IMM_J;
      default:                      imm_fmt = IMM_NONE;
    endcase
  endfunction

  assign cls = classify(opcode);

  // Next-state, watchdog and trap-cause logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == TIMEOUT) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DECODE: begin
        if (cls == CL_ILLEGAL) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls)
          CL_BRANCH: begin
            state_d = S_FETCH;
            wait_d  = '0;
          end
          CL_LOAD, CL_STORE: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls == CL_STORE) begin
            state_d = S_FETCH;
            wait_d  = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == TIMEOUT) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // Datapath strobes and selects, decoded straight from state, opcode and ready inputs
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    alu_src_imm = 1'b0;
    imm_sel     = IMM_NONE;
    retire      = 1'b0;

    if (state_q == S_DECODE || state_q == S_EXECUTE ||
        state_q == S_MEM    || state_q == S_WB) begin
      imm_sel = imm_fmt(cls);
    end
    if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB) begin
      alu_src_imm = !(cls == CL_OP || cls == CL_BRANCH || cls == CL_ILLEGAL);
    end

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXECUTE: begin
        if (cls == CL_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CL_STORE);
        if (dmem_ready && cls == CL_STORE) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        case (cls)
          CL_JAL: begin
            wb_sel = WB_LINK;
            pc_sel = PC_IMM;
          end
          CL_JALR: begin
            wb_sel = WB_LINK;
            pc_sel = PC_ALU;
          end
          CL_LOAD: wb_sel = WB_MEM;
          default: wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  assign halted     = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule
